// File: rtl/stack_cpu_seq.sv
// stack_cpu_seq: round-robin multi-context control sequencer between IFIDC and EXEC.
// Each context owns a PC and a running flag. Contexts get one instruction per turn.
// A watchdog bounds the time spent waiting on EXEC, and a saturating counter tracks
// retired instructions.
// Optional feature: define STACK_CPU_SEQ_STEP_EN to add a 'step' input. With it,
// SELECT holds until step=1 is seen, but the transition to IDLE never waits for step.
module stack_cpu_seq #(
   parameter int unsigned NUM_THREADS  = 2,
   parameter int unsigned TID_LEN      = $clog2(NUM_THREADS),
   parameter int unsigned PC_LEN       = 6,
   parameter int unsigned EXEC_TIMEOUT = 64,
   parameter int unsigned CNT_LEN      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   go,
   input  logic                   exec_fin_sig,
   input  logic                   exec_halt,
   input  logic [PC_LEN-1:0]      exec_pc,
`ifdef STACK_CPU_SEQ_STEP_EN
   input  logic                   step,
`endif
   output logic                   ifidc_en,
   output logic                   exec_en,
   output logic [PC_LEN-1:0]      pc_out,
   output logic [TID_LEN-1:0]     thread_id,
   output logic [NUM_THREADS-1:0] thread_active,
   output logic                   busy,
   output logic                   err_timeout,
   output logic [CNT_LEN-1:0]     inst_count
);

   localparam int unsigned WD_LEN = $clog2(EXEC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_WAIT   = 3'd3,
      S_SELECT = 3'd4
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [PC_LEN-1:0]      r_pc     [NUM_THREADS];
   logic [PC_LEN-1:0]      w_pc_nxt [NUM_THREADS];
   logic [TID_LEN-1:0]     r_tid, w_tid_nxt;
   logic [NUM_THREADS-1:0] r_active, w_active_nxt;
   logic [CNT_LEN-1:0]     r_cnt, w_cnt_nxt;
   logic [WD_LEN-1:0]      r_wdog, w_wdog_nxt;
   logic                   r_err, w_err_nxt;
   logic                   w_step;
   logic                   w_found;
   logic [TID_LEN-1:0]     w_sel;

`ifdef STACK_CPU_SEQ_STEP_EN
   assign w_step = step;
`else
   assign w_step = 1'b1;
`endif

   // Round-robin search for the next active context, starting after the current one
   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_sel   = r_tid;
      for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
         idx = (32'(r_tid) + k) % NUM_THREADS;
         if (!w_found && r_active[TID_LEN'(idx)]) begin
            w_found = 1'b1;
            w_sel   = TID_LEN'(idx);
         end
      end
   end

   // Next-state and datapath update logic
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_tid_nxt    = r_tid;
      w_active_nxt = r_active;
      w_cnt_nxt    = r_cnt;
      w_wdog_nxt   = r_wdog;
      w_err_nxt    = r_err;
      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_active_nxt = '1;
               for (int i = 0; i < NUM_THREADS; i++) w_pc_nxt[i] = '0;
               w_tid_nxt    = '0;
               w_err_nxt    = 1'b0;
               w_wdog_nxt   = '0;
               w_state_nxt  = S_FETCH;
            end
         end
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            w_wdog_nxt  = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (exec_fin_sig) begin
               w_pc_nxt[r_tid] = exec_pc;
               if (exec_halt) w_active_nxt[r_tid] = 1'b0;
               if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_LEN'(1);
               w_state_nxt = S_SELECT;
            end else if (r_wdog == WD_LEN'(EXEC_TIMEOUT - 1)) begin
               w_err_nxt           = 1'b1;
               w_active_nxt[r_tid] = 1'b0;
               w_state_nxt         = S_SELECT;
            end else begin
               w_wdog_nxt = r_wdog + WD_LEN'(1);
            end
         end
         S_SELECT: begin
            if (!w_found) begin
               w_state_nxt = S_IDLE;
            end else if (w_step) begin
               w_tid_nxt   = w_sel;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and context registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         for (int i = 0; i < NUM_THREADS; i++) r_pc[i] <= '0;
         r_tid    <= '0;
         r_active <= '0;
         r_cnt    <= '0;
         r_wdog   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_tid    <= w_tid_nxt;
         r_active <= w_active_nxt;
         r_cnt    <= w_cnt_nxt;
         r_wdog   <= w_wdog_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Outputs decoded from registered state only
   assign ifidc_en      = (r_state == S_FETCH);
   assign exec_en       = (r_state == S_EXEC);
   assign busy          = (r_state != S_IDLE);
   assign pc_out        = r_pc[r_tid];
   assign thread_id     = r_tid;
   assign thread_active = r_active;
   assign err_timeout   = r_err;
   assign inst_count    = r_cnt;

endmodule

// File: tb/tb_stack_cpu_seq.sv
// Testbench for stack_cpu_seq: directed instruction sequences, with a scoreboard
// checking the context state presented at every fetch and at every return to idle.
module tb_stack_cpu_seq;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       go;
   logic       fin;
   logic       halt;
   logic [5:0] epc;
`ifdef STACK_CPU_SEQ_STEP_EN
   logic       step;
`endif
   logic       ifidc_en, exec_en, busy, err_timeout;
   logic [5:0] pc_out;
   logic [0:0] thread_id;
   logic [1:0] thread_active;
   logic [15:0] inst_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit idle;
      int tid;
      int pc;
      int act;
      int cnt;
      int err;
   } exp_t;

   exp_t q[$];

   stack_cpu_seq #(.EXEC_TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .exec_fin_sig (fin),
      .exec_halt    (halt),
      .exec_pc      (epc),
`ifdef STACK_CPU_SEQ_STEP_EN
      .step         (step),
`endif
      .ifidc_en     (ifidc_en),
      .exec_en      (exec_en),
      .pc_out       (pc_out),
      .thread_id    (thread_id),
      .thread_active(thread_active),
      .busy         (busy),
      .err_timeout  (err_timeout),
      .inst_count   (inst_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic void push_fetch(input int tid, input int pc, input int act,
                                      input int cnt, input int err);
      exp_t e;
      e.idle = 1'b0; e.tid = tid; e.pc = pc; e.act = act; e.cnt = cnt; e.err = err;
      q.push_back(e);
   endfunction

   function automatic void push_idle(input int cnt, input int err);
      exp_t e;
      e.idle = 1'b1; e.tid = 0; e.pc = 0; e.act = 0; e.cnt = cnt; e.err = err;
      q.push_back(e);
   endfunction

   // Monitor: pops one expectation per fetch pulse or per busy falling edge
   bit prev_busy = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
      end else begin
         if (ifidc_en || (prev_busy && !busy)) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event: fetch=%0d busy=%0d with empty scoreboard",
                        ifidc_en, busy);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.idle) begin
                  if (ifidc_en || int'(thread_active) != e.act ||
                      int'(inst_count) != e.cnt || int'(err_timeout) != e.err) begin
                     bad++;
                     $display("FAIL idle: got fetch=%0d act=%b cnt=%0d err=%0d want fetch=0 act=%b cnt=%0d err=%0d",
                              ifidc_en, thread_active, inst_count, err_timeout,
                              e.act[1:0], e.cnt, e.err);
                  end
               end else begin
                  if (!ifidc_en || int'(thread_id) != e.tid || int'(pc_out) != e.pc ||
                      int'(thread_active) != e.act || int'(inst_count) != e.cnt ||
                      int'(err_timeout) != e.err) begin
                     bad++;
                     $display("FAIL fetch: got fetch=%0d tid=%0d pc=%0d act=%b cnt=%0d err=%0d want fetch=1 tid=%0d pc=%0d act=%b cnt=%0d err=%0d",
                              ifidc_en, thread_id, pc_out, thread_active, inst_count,
                              err_timeout, e.tid, e.pc, e.act[1:0], e.cnt, e.err);
                  end
               end
            end
         end
         prev_busy = busy;
      end
   end

   // Wait (bounded) for the EXEC pulse; returns in the EXEC cycle
   task automatic wait_exec();
      int n = 0;
      while (!exec_en && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!exec_en) chk("exec_en_timeout", 0, 1);
   endtask

   // Act as EXEC for one instruction; delay<0 means never finish (watchdog)
   task automatic do_inst(input int delay, input logic [5:0] npc, input logic h);
      wait_exec();
      @(posedge clk); #1;
      if (delay < 0) begin
         repeat (TO - 1) begin @(posedge clk); #1; end
         chk("wd_before_fire", int'(err_timeout), 0);
         @(posedge clk); #1;
         chk("wd_fire", int'(err_timeout), 1);
         @(posedge clk); #1;
         chk("wd_refetch", int'(ifidc_en), 1);
      end else begin
         repeat (delay) begin @(posedge clk); #1; end
         fin = 1'b1; epc = npc; halt = h;
         @(posedge clk); #1;
         fin = 1'b0; halt = 1'b0;
      end
   endtask

   task automatic pulse_go();
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; fin = 1'b0; halt = 1'b0; epc = '0;
`ifdef STACK_CPU_SEQ_STEP_EN
      step = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", int'({busy, ifidc_en, exec_en, err_timeout}), 0);
      chk("rst_pc_tid", int'({pc_out, thread_id}), 0);
      chk("rst_active_cnt", int'({thread_active, inst_count}), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Start: fetch then exec, both contexts running
      push_fetch(0, 0, 3, 0, 0);
      pulse_go();
      chk("go_fetch", int'({ifidc_en, exec_en, busy}), 3'b101);
      chk("go_active", int'(thread_active), 3);
      @(posedge clk); #1;
      chk("go_exec", int'({ifidc_en, exec_en}), 2'b01);

      // Round-robin with per-context PCs
`ifdef STACK_CPU_SEQ_STEP_EN
      step = 1'b0;
`endif
      push_fetch(1, 0, 3, 1, 0);
      do_inst(0, 6'd5, 1'b0);
`ifdef STACK_CPU_SEQ_STEP_EN
      repeat (4) begin
         @(posedge clk); #1;
         chk("step_hold", int'(ifidc_en), 0);
      end
      step = 1'b1;
      @(posedge clk); #1;
      chk("step_fetch", int'(ifidc_en), 1);
`endif
      push_fetch(0, 5, 3, 2, 0);
      do_inst(0, 6'd3, 1'b0);
      go = 1'b1;
      push_fetch(1, 3, 3, 3, 0);
      do_inst(3, 6'd9, 1'b0);
      go = 1'b0;

      // Context 1 halts, context 0 runs back-to-back then halts
      push_fetch(0, 9, 1, 4, 0);
      do_inst(0, 6'd4, 1'b1);
      push_fetch(0, 10, 1, 5, 0);
      do_inst(0, 6'd10, 1'b0);
      push_idle(6, 0);
      do_inst(0, 6'd11, 1'b1);
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_pc_out", int'(pc_out), 11);

      // Restart: PCs cleared, count kept; fin on last watchdog cycle, then a timeout
      push_fetch(0, 0, 3, 6, 0);
      pulse_go();
      push_fetch(1, 0, 3, 7, 0);
      do_inst(TO - 1, 6'd7, 1'b0);
      chk("fin_wins", int'(err_timeout), 0);
      push_fetch(0, 7, 1, 7, 1);
      do_inst(-1, 6'd0, 1'b0);
      push_idle(8, 1);
      do_inst(0, 6'd1, 1'b1);
      @(posedge clk); #1;
      chk("idle2_busy", int'(busy), 0);

      // Restart clears the error; async reset in the middle of WAIT
      push_fetch(0, 0, 3, 8, 0);
      pulse_go();
      push_fetch(1, 0, 3, 9, 0);
      do_inst(0, 6'd6, 1'b0);
      wait_exec();
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", int'({busy, ifidc_en, exec_en, err_timeout}), 0);
      chk("arst_pc_tid", int'({pc_out, thread_id}), 0);
      chk("arst_active_cnt", int'({thread_active, inst_count}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      push_fetch(0, 0, 3, 0, 0);
      pulse_go();
      push_fetch(1, 0, 2, 1, 0);
      do_inst(0, 6'd0, 1'b1);
      push_idle(2, 0);
      do_inst(0, 6'd0, 1'b1);
      @(posedge clk); #1;
      chk("idle3_busy", int'(busy), 0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_cpu_seq.md
Name: stack_cpu_seq

Overview:
Multi-context control sequencer for the stack CPU. It generalises the single-thread IFIDC/EXEC/WAIT controller to NUM_THREADS hardware contexts, each with its own PC. Contexts are scheduled round-robin, one instruction per turn, and each context can halt independently. It adds an execution watchdog and an instruction counter, and sits between the IFIDC and EXEC units in the CPU top.

Parameters:
NUM_THREADS, 2, number of hardware contexts (>=2)
TID_LEN, 1, thread-id width, = $clog2(NUM_THREADS)
PC_LEN, 6, PC width, matches the EXEC pc port ($clog2(INST_CAP)+1 for INST_CAP=20)
EXEC_TIMEOUT, 64, max WAIT cycles before watchdog fires (>=1)
CNT_LEN, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
go  in  1  start all contexts from PC 0; accepted only in IDLE
exec_fin_sig  in  1  EXEC finished the current instruction
exec_halt  in  1  qualifies exec_fin_sig: instruction was HALT
exec_pc  in  PC_LEN  next PC from EXEC, valid with exec_fin_sig
ifidc_en  out  1  fetch/decode enable pulse
exec_en  out  1  execute enable pulse
pc_out  out  PC_LEN  PC of the selected context, to IFIDC
thread_id  out  TID_LEN  selected context
thread_active  out  NUM_THREADS  per-context running flags
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky watchdog error
inst_count  out  CNT_LEN  retired instructions, saturating

Behaviour:
- Reset (async, any state): state=IDLE; all PCs, thread_id, thread_active, inst_count, watchdog counter = 0; ifidc_en, exec_en, busy, err_timeout = 0.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, FETCH, EXEC, WAIT, SELECT.
- IDLE, go=1:
  - thread_active = all ones; all PCs = 0; thread_id = 0.
  - err_timeout and watchdog counter cleared; inst_count NOT cleared.
  - Next state FETCH.
- IDLE, go=0: stay in IDLE.
- go outside IDLE is ignored.
- FETCH: ifidc_en=1 for exactly this cycle. Next state EXEC.
- EXEC: exec_en=1 for exactly this cycle. Watchdog counter = 0. Next state WAIT.
- WAIT, on each cycle:
  - exec_fin_sig=1:
    - pc[thread_id] = exec_pc.
    - If exec_halt=1, thread_active[thread_id] = 0.
    - inst_count += 1, saturating at all ones.
    - Next state SELECT.
  - exec_fin_sig=0, counter == EXEC_TIMEOUT-1:
    - err_timeout = 1.
    - thread_active[thread_id] = 0; PC unchanged.
    - Next state SELECT.
  - Otherwise counter += 1.
  - If fin arrives on the timeout cycle, fin wins and there is no error.
- exec_fin_sig and exec_halt are ignored outside WAIT.
- SELECT (1 cycle):
  - Search (thread_id+1 .. thread_id+NUM_THREADS) mod NUM_THREADS for the first active context, using thread_active as updated in WAIT.
  - Found: thread_id = that context; next state FETCH. The current context is reselected if it is the only one active.
  - None found: next state IDLE.
- pc_out = pc[thread_id] in all states; stable from FETCH through WAIT.
- busy = (state != IDLE).
- Minimum instruction cost: 4 cycles (FETCH, EXEC, one WAIT cycle, SELECT).
- exec_pc wraps naturally at PC_LEN; no range check.

Optional Feature:
- Macro: STACK_CPU_SEQ_STEP_EN.
- Defined:
  - Extra input port step (1 bit).
  - SELECT holds until step=1; when step=1 it performs the SELECT action that cycle.
  - Transition to IDLE (no active contexts) does not wait for step.
- Undefined: no step port; SELECT always completes in 1 cycle.

Test Plan:
1. rst pulse, then go=1 sampled at edge k -> ifidc_en=1 in cycle k+1, exec_en=1 in cycle k+2, thread_id=0, pc_out=0, busy=1, thread_active=2'b11.
2. First WAIT cycle: fin=1, exec_pc=5 (thread 0), then thread 1 fin with exec_pc=3 -> pc_out=0 on thread 1's fetch; next thread 0 fetch pc_out=5; inst_count=2.
3. Thread 1 fin with exec_halt=1 -> thread_active=2'b01; thread 0 scheduled back-to-back; thread 0 halts -> IDLE, busy=0, go re-accepted.
4. EXEC_TIMEOUT=8, fin held low -> err_timeout=1 after exactly 8 WAIT cycles, that context deactivated, other context continues. Fin on the 8th cycle -> no error.
5. rst asserted mid-WAIT -> outputs 0 immediately, without waiting for clk. A subsequent go restarts with pc_out=0, inst_count=0.
6. With STACK_CPU_SEQ_STEP_EN, step=0 -> FSM remains in SELECT, ifidc_en stays 0. One-cycle step pulse -> exactly one FETCH follows.
